acc_op_sequencer: RTL and testbench

//  Upstream control stage for the 16-bit accumulator ALU. Accepts one instruction per handshake and fetches the DR operand from memory when needed.

---
 rtl/acc_op_sequencer_pkg.sv | 28 ++
 rtl/acc_op_sequencer_if.sv | 27 ++
 rtl/acc_op_sequencer_mem_if.sv | 39 +++
 rtl/acc_op_sequencer.sv | 109 ++++++++++
 tb/tb_acc_op_sequencer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_op_sequencer_pkg.sv
// Shared op codes, FSM state type and op-class helpers for the accumulator sequencer.
// Pure definitions: no latency and no handshake of its own.
package acc_seq_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_ADD = 3'b000;
  localparam op_t OP_AND = 3'b001;
  localparam op_t OP_CMA = 3'b010;
  localparam op_t OP_INC = 3'b011;
  localparam op_t OP_DEC = 3'b100;
  localparam op_t OP_LDI = 3'b101;
  localparam op_t OP_NOP = 3'b110;
  localparam op_t OP_LDE = 3'b111;

  localparam op_t ALU_IDLE_CTRL = 3'b110;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;

  function automatic logic is_mem_op(input op_t op);
    return (op == OP_ADD) || (op == OP_AND);
  endfunction

  function automatic logic writes_e(input op_t op);
    return (op == OP_ADD) || (op == OP_INC) || (op == OP_DEC);
  endfunction

endpackage

// File: rtl/acc_op_sequencer_if.sv
// Instruction handshake and operand-read bus; slave = sequencer, master = issuer/memory side.
// Wires only: no latency; instr_ready and mem_ack carry the backpressure.
interface acc_op_sequencer_if
  import acc_seq_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 16
);
  logic          instr_valid;
  logic          instr_ready;
  op_t           instr_op;
  logic [AW-1:0] instr_addr;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  instr_valid, instr_op, instr_addr, mem_ack, mem_rdata,
    output instr_ready, mem_req, mem_addr
  );

  modport master (
    output instr_valid, instr_op, instr_addr, mem_ack, mem_rdata,
    input  instr_ready, mem_req, mem_addr
  );
endinterface

// File: rtl/acc_op_sequencer_mem_if.sv
// Operand read port: holds mem_req/mem_addr from accept until ack and captures DR on ack.
// Request drops the cycle after the ack edge; waits indefinitely while mem_ack stays low.
module acc_seq_mem_if #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          fetch,
  input  logic [AW-1:0] load_addr,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] dr,
  output logic          fetch_done
);

  // An ack only counts while a request is outstanding; strays are dropped.
  assign fetch_done = mem_req & mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
      dr       <= '0;
    end else begin
      if (load) begin
        mem_addr <= load_addr;
        mem_req  <= fetch;
      end else if (fetch_done) begin
        mem_req <= 1'b0;
      end
      if (fetch_done) dr <= mem_rdata;
    end
  end

endmodule

// File: rtl/acc_op_sequencer.sv
// Accumulator ALU sequencer: IDLE->FETCH(ADD/AND)->EXEC->WB; z_flag port only with ACC_SEQ_ZFLAG_EN.
// Latency 3 cycles plus memory wait; instr_ready is high only in IDLE, so issue is at most one op per 3 cycles.
module acc_op_sequencer
  import acc_seq_pkg::*;
#(
  parameter int DW  = 16,
  parameter int AW  = 12,
  parameter int IPW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  acc_op_sequencer_if.slave bus,
  output op_t            alu_ctrl,
  output logic           alu_cin,
  output logic [DW-1:0]  alu_ac,
  output logic [DW-1:0]  alu_dr,
  output logic [IPW-1:0] alu_ip,
  input  logic [DW-1:0]  alu_out,
  input  logic           alu_cout,
  output logic [DW-1:0]  ac,
  output logic           e_flag,
  output logic           done
`ifdef ACC_SEQ_ZFLAG_EN
  ,
  output logic           z_flag
`endif
);

  state_t         state;
  op_t            op_q;
  logic [IPW-1:0] ip_q;
  logic [DW-1:0]  ac_q;
  logic [DW-1:0]  dr;
  logic           e_q;
  logic           done_q;
  logic           accept;
  logic           fetch_done;

  assign bus.instr_ready = (state == IDLE);
  assign accept          = (state == IDLE) && bus.instr_valid;

  acc_seq_mem_if #(.AW(AW), .DW(DW)) u_mem (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .fetch      (is_mem_op(bus.instr_op)),
    .load_addr  (bus.instr_addr),
    .mem_req    (bus.mem_req),
    .mem_addr   (bus.mem_addr),
    .mem_ack    (bus.mem_ack),
    .mem_rdata  (bus.mem_rdata),
    .dr         (dr),
    .fetch_done (fetch_done)
  );

  // Ctrl parks on the idle code outside EXEC/WB so each op gives the ALU a Ctrl edge.
  assign alu_ctrl = ((state == EXEC) || (state == WB)) ? op_q : ALU_IDLE_CTRL;
  assign alu_cin  = e_q;
  assign alu_ac   = ac_q;
  assign alu_dr   = dr;
  assign alu_ip   = ip_q;
  assign ac       = ac_q;
  assign e_flag   = e_q;
  assign done     = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= OP_NOP;
      ip_q   <= '0;
      ac_q   <= '0;
      e_q    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.instr_valid) begin
            op_q  <= bus.instr_op;
            ip_q  <= bus.instr_addr[IPW-1:0];
            state <= is_mem_op(bus.instr_op) ? FETCH : EXEC;
          end
        end
        FETCH: begin
          if (fetch_done) state <= EXEC;
        end
        EXEC: state <= WB;
        WB: begin
          if (op_q != OP_NOP) ac_q <= alu_out;
          if (writes_e(op_q)) e_q <= alu_cout;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ACC_SEQ_ZFLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_flag <= 1'b0;
    end else if ((state == WB) && (op_q != OP_NOP)) begin
      z_flag <= (alu_out == '0);
    end
  end
`endif

endmodule

// File: tb/tb_acc_op_sequencer.sv
// Scenario bench for acc_op_sequencer with a behavioural ALU and a wait-state memory responder.
module tb_acc_op_sequencer;
  import acc_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  op_t         alu_ctrl;
  logic        alu_cin;
  logic [15:0] alu_ac;
  logic [15:0] alu_dr;
  logic [7:0]  alu_ip;
  logic [15:0] alu_out;
  logic        alu_cout;
  logic [15:0] ac;
  logic        e_flag;
  logic        done;
`ifdef ACC_SEQ_ZFLAG_EN
  logic        z_flag;
`endif

  int errors = 0;
  int checks = 0;

  logic [15:0] sb_ac[$];
  logic        sb_e[$];

  int          ack_wait  = 0;
  int          wait_cnt  = 0;
  logic [15:0] mem_word  = 16'h0000;
  logic        stray_ack = 1'b0;

  acc_op_sequencer_if #(.AW(12), .DW(16)) bus ();

  acc_op_sequencer #(.DW(16), .AW(12), .IPW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_ctrl (alu_ctrl),
    .alu_cin  (alu_cin),
    .alu_ac   (alu_ac),
    .alu_dr   (alu_dr),
    .alu_ip   (alu_ip),
    .alu_out  (alu_out),
    .alu_cout (alu_cout),
    .ac       (ac),
    .e_flag   (e_flag),
    .done     (done)
`ifdef ACC_SEQ_ZFLAG_EN
    ,
    .z_flag   (z_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: DEC carry-out means "no borrow".
  always_comb begin
    alu_out  = alu_ac;
    alu_cout = 1'b0;
    case (alu_ctrl)
      OP_ADD: {alu_cout, alu_out} = {1'b0, alu_ac} + {1'b0, alu_dr};
      OP_AND: alu_out = alu_ac & alu_dr;
      OP_CMA: alu_out = ~alu_ac;
      OP_INC: {alu_cout, alu_out} = {1'b0, alu_ac} + 17'd1;
      OP_DEC: begin alu_out = alu_ac - 16'd1; alu_cout = (alu_ac != 16'h0000); end
      OP_LDI: alu_out = {8'h00, alu_ip};
      OP_LDE: alu_out = {15'b0, alu_cin};
      default: alu_out = alu_ac;
    endcase
  end

  always @(negedge clk) begin
    if (stray_ack) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 16'h1234;
    end else if (bus.mem_ack) begin
      bus.mem_ack = 1'b0;
      wait_cnt    = 0;
    end else if (bus.mem_req) begin
      if (wait_cnt == ack_wait) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_word;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Scoreboard: every done pulse pops one expected AC/E pair.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_ac.size() == 0) begin
        errors++; checks++;
        $display("FAIL sb_unexpected_done: got done=1 with ac=%h, required no done", ac);
      end else begin
        logic [15:0] eac;
        logic        ee;
        eac = sb_ac.pop_front();
        ee  = sb_e.pop_front();
        checks++;
        if (ac !== eac) begin
          errors++;
          $display("FAIL sb_ac: got %h, required %h", ac, eac);
        end
        checks++;
        if (e_flag !== ee) begin
          errors++;
          $display("FAIL sb_e: got %b, required %b", e_flag, ee);
        end
      end
    end
  end

  // Issues one op and follows it to done; lat counts negedges after the accept edge (-1 on timeout).
  task automatic run_op(input op_t op, input logic [11:0] addr, input logic [15:0] exp_ac,
                        input logic exp_e, output int lat, output int reqs, output logic addr_ok,
                        output op_t c_exec, output op_t c_wb, output op_t c_after);
    int   k;
    logic got;
    sb_ac.push_back(exp_ac);
    sb_e.push_back(exp_e);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.instr_ready) break;
    end
    bus.instr_valid = 1'b1;
    bus.instr_op    = op;
    bus.instr_addr  = addr;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    lat = 0; reqs = 0; addr_ok = 1'b1; k = 0; got = 1'b0;
    c_exec = 3'bxxx; c_wb = 3'bxxx; c_after = 3'bxxx;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (bus.mem_req) begin
        reqs++;
        if (bus.mem_addr !== addr) addr_ok = 1'b0;
      end else begin
        k++;
        if (k == 1) c_exec = alu_ctrl;
        if (k == 2) c_wb = alu_ctrl;
        if (k == 3) c_after = alu_ctrl;
      end
      if (done) got = 1'b1;
    end
    if (!got) begin
      lat = -1;
      errors++; checks++;
      $display("FAIL op_timeout: op=%b got no done within 60 cycles, required done", op);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.instr_valid = 1'b0; bus.instr_op = OP_NOP; bus.instr_addr = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b, required 1", bus.instr_ready); end
    checks++; if (ac !== 16'h0000) begin errors++; $display("FAIL rst_ac: got %h, required 0000", ac); end
    checks++; if (e_flag !== 1'b0) begin errors++; $display("FAIL rst_e: got %b, required 0", e_flag); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, required 0", done); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b, required 0", bus.mem_req); end
    checks++; if (alu_ctrl !== 3'b110) begin errors++; $display("FAIL rst_ctrl: got %b, required 110", alu_ctrl); end
    rst_n = 1'b1;
  endtask

  task automatic test_inc_from_zero;
    int lat, reqs; logic aok; op_t c1, c2, c3;
    run_op(OP_INC, 12'h000, 16'h0001, 1'b0, lat, reqs, aok, c1, c2, c3);
    checks++; if (lat !== 3) begin errors++; $display("FAIL inc_latency: got %0d, required 3", lat); end
    checks++; if (c3 !== 3'b110) begin errors++; $display("FAIL inc_ctrl_idle: got %b, required 110", c3); end
  endtask

  task automatic test_ldi_inc;
    int lat, reqs; logic aok; op_t c1, c2, c3;
    run_op(OP_LDI, 12'hAFF, 16'h00FF, 1'b0, lat, reqs, aok, c1, c2, c3);
    checks++; if (alu_ip !== 8'hFF) begin errors++; $display("FAIL ldi_ip: got %h, required ff", alu_ip); end
    run_op(OP_INC, 12'h000, 16'h0100, 1'b0, lat, reqs, aok, c1, c2, c3);
    checks++; if (c3 !== 3'b110) begin errors++; $display("FAIL inc1_ctrl_after: got %b, required 110", c3); end
    run_op(OP_INC, 12'h000, 16'h0101, 1'b0, lat, reqs, aok, c1, c2, c3);
    checks++; if (c1 !== 3'b011) begin errors++; $display("FAIL inc2_ctrl_exec: got %b, required 011", c1); end
    checks++; if (c2 !== 3'b011) begin errors++; $display("FAIL inc2_ctrl_wb: got %b, required 011", c2); end
    checks++; if (c3 !== 3'b110) begin errors++; $display("FAIL inc2_ctrl_after: got %b, required 110", c3); end
  endtask

  task automatic test_add_fetch;
    int lat, reqs; logic aok; op_t c1, c2, c3;
    run_op(OP_LDI, 12'h000, 16'h0000, 1'b0, lat, reqs, aok, c1, c2, c3);
    run_op(OP_CMA, 12'h000, 16'hFFFF, 1'b0, lat, reqs, aok, c1, c2, c3);
    ack_wait = 4; mem_word = 16'h0001;
    run_op(OP_ADD, 12'h010, 16'h0000, 1'b1, lat, reqs, aok, c1, c2, c3);
    checks++; if (reqs !== 5) begin errors++; $display("FAIL add_req_cycles: got %0d, required 5", reqs); end
    checks++; if (aok !== 1'b1) begin errors++; $display("FAIL add_mem_addr: addr moved off 010 during req, required stable"); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL add_latency: got %0d, required 8", lat); end
    checks++; if (c1 !== OP_ADD) begin errors++; $display("FAIL add_ctrl_exec: got %b, required 000", c1); end
  endtask

  task automatic test_and_keeps_e;
    int lat, reqs; logic aok; op_t c1, c2, c3;
    ack_wait = 0;
    run_op(OP_LDI, 12'h0F0, 16'h00F0, 1'b1, lat, reqs, aok, c1, c2, c3);
    mem_word = 16'h0F3C;
    run_op(OP_AND, 12'h123, 16'h0030, 1'b1, lat, reqs, aok, c1, c2, c3);
    checks++; if (reqs !== 1) begin errors++; $display("FAIL and_req_cycles: got %0d, required 1", reqs); end
    checks++; if (alu_dr !== 16'h0F3C) begin errors++; $display("FAIL and_dr: got %h, required 0f3c", alu_dr); end
  endtask

  task automatic test_lde_dec;
    int lat, reqs; logic aok; op_t c1, c2, c3;
    run_op(OP_LDE, 12'h000, 16'h0001, 1'b1, lat, reqs, aok, c1, c2, c3);
    run_op(OP_DEC, 12'h000, 16'h0000, 1'b1, lat, reqs, aok, c1, c2, c3);
    run_op(OP_DEC, 12'h000, 16'hFFFF, 1'b0, lat, reqs, aok, c1, c2, c3);
    run_op(OP_NOP, 12'h000, 16'hFFFF, 1'b0, lat, reqs, aok, c1, c2, c3);
    checks++; if (c1 !== 3'b110) begin errors++; $display("FAIL nop_ctrl: got %b, required 110", c1); end
  endtask

  task automatic test_reset_in_fetch;
    int lat, reqs; logic aok; op_t c1, c2, c3;
    ack_wait = 1000;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.instr_ready) break;
    end
    bus.instr_valid = 1'b1; bus.instr_op = OP_ADD; bus.instr_addr = 12'h055;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rf_req_before: got %b, required 1", bus.mem_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rf_req_async: got %b, required 0", bus.mem_req); end
    checks++; if (ac !== 16'h0000) begin errors++; $display("FAIL rf_ac: got %h, required 0000", ac); end
    checks++; if (alu_dr !== 16'h0000) begin errors++; $display("FAIL rf_dr: got %h, required 0000", alu_dr); end
    @(negedge clk);
    rst_n = 1'b1;
    ack_wait = 0;
    @(posedge clk);
    #1 stray_ack = 1'b1;
    @(posedge clk);
    #1 stray_ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (alu_dr !== 16'h0000) begin errors++; $display("FAIL stray_dr: got %h, required 0000", alu_dr); end
    checks++; if (ac !== 16'h0000) begin errors++; $display("FAIL stray_ac: got %h, required 0000", ac); end
    checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL stray_ready: got %b, required 1", bus.instr_ready); end
    run_op(OP_INC, 12'h000, 16'h0001, 1'b0, lat, reqs, aok, c1, c2, c3);
  endtask

  initial begin
    test_reset();
    test_inc_from_zero();
    test_ldi_inc();
    test_add_fetch();
    test_and_keeps_e();
    test_lde_dec();
    test_reset_in_fetch();
    repeat (3) @(negedge clk);
    checks++;
    if (sb_ac.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending results, required 0", sb_ac.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
